// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from N_REQ requesters
// into one shared uart_tx, pacing frames on its ready_to_send status and
// recovering from launches the transmitter never acknowledges.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int LAUNCH_TIMEOUT = 325*16*4,
  parameter int GUARD_CLKS     = 325*16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     uart_ready,
  output logic                     uart_start_n,
  output logic [7:0]               uart_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     clr_err
);

  localparam int IW   = $clog2(N_REQ);
  localparam int CMAX = (LAUNCH_TIMEOUT > GUARD_CLKS) ? LAUNCH_TIMEOUT : GUARD_CLKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0]    LT_LAST  = CW'(LAUNCH_TIMEOUT - 1);
  localparam logic [CW-1:0]    GC_LAST  = CW'(GUARD_CLKS - 1);
  localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2,
    GUARD  = 2'd3
  } state_t;

  state_t state_r, state_nx_s;

  logic             rdy_meta_r, rdy_sync_r, rdy_s;
  logic [1:0]       warm_r;
  logic [IW-1:0]    last_r, last_nx_s, gid_r, gid_nx_s, win_idx_s, idx_v;
  logic             win_found_s, grant_s, timeout_s, lt_hit_s, gc_hit_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic [N_REQ-1:0] ack_r, ack_nx_s;
  logic [7:0]       data_r, data_nx_s;
  logic             start_n_r, start_n_nx_s, busy_r, busy_nx_s, err_r, err_nx_s;

  // Two-flop synchronizer for ready_to_send; warm_r blocks grants until the
  // synchronizer holds real samples instead of its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_meta_r <= 1'b1;
      rdy_sync_r <= 1'b1;
      warm_r     <= 2'b00;
    end else begin
      rdy_meta_r <= uart_ready;
      rdy_sync_r <= rdy_meta_r;
      warm_r     <= {warm_r[0], 1'b1};
    end
  end

  assign rdy_s = rdy_sync_r;

  // Round-robin search from last_r+1; iterating backwards lets the nearest hit win.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    idx_v       = {IW{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      idx_v = IW'((int'(last_r) + k) % N_REQ);
      if (req_valid[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  assign grant_s   = (state_r == IDLE) && rdy_s && warm_r[1] && win_found_s;
  assign lt_hit_s  = (cnt_r == LT_LAST);
  assign gc_hit_s  = (cnt_r == GC_LAST);
  assign timeout_s = (state_r == LAUNCH) && rdy_s && lt_hit_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_nx_s = LAUNCH;
        else         state_nx_s = IDLE;
      end
      LAUNCH: begin
        if (!rdy_s)        state_nx_s = DRAIN;
        else if (lt_hit_s) state_nx_s = DRAIN;
        else               state_nx_s = LAUNCH;
      end
      DRAIN: begin
        if (rdy_s) state_nx_s = GUARD;
        else       state_nx_s = DRAIN;
      end
      GUARD: begin
        if (gc_hit_s) state_nx_s = IDLE;
        else          state_nx_s = GUARD;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM output logic: next values for every registered output and datapath flop.
  always_comb begin
    ack_nx_s     = {N_REQ{1'b0}};
    data_nx_s    = data_r;
    gid_nx_s     = gid_r;
    last_nx_s    = last_r;
    start_n_nx_s = (state_nx_s != LAUNCH);
    busy_nx_s    = (state_nx_s != IDLE);

    if (grant_s) begin
      ack_nx_s  = ONE_HOT0 << win_idx_s;
      data_nx_s = req_data[{win_idx_s, 3'b000} +: 8];
      gid_nx_s  = win_idx_s;
      last_nx_s = win_idx_s;
    end else begin
      ack_nx_s  = {N_REQ{1'b0}};
    end

    // Counter restarts on every state change and saturates while counting.
    if (state_nx_s != state_r) begin
      cnt_nx_s = CNT_ZERO;
    end else if (((state_r == LAUNCH) || (state_r == GUARD)) && (cnt_r != CNT_SAT)) begin
      cnt_nx_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nx_s = cnt_r;
    end

    // A timeout in the same cycle as clr_err keeps the flag set.
    if (timeout_s)    err_nx_s = 1'b1;
    else if (clr_err) err_nx_s = 1'b0;
    else              err_nx_s = err_r;
  end

  // Registered outputs, round-robin pointer and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= {N_REQ{1'b0}};
      data_r    <= 8'h00;
      gid_r     <= {IW{1'b0}};
      last_r    <= LAST_RST;
      cnt_r     <= CNT_ZERO;
      start_n_r <= 1'b1;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      ack_r     <= ack_nx_s;
      data_r    <= data_nx_s;
      gid_r     <= gid_nx_s;
      last_r    <= last_nx_s;
      cnt_r     <= cnt_nx_s;
      start_n_r <= start_n_nx_s;
      busy_r    <= busy_nx_s;
      err_r     <= err_nx_s;
    end
  end

  assign req_ack      = ack_r;
  assign uart_data    = data_r;
  assign grant_id     = gid_r;
  assign uart_start_n = start_n_r;
  assign busy         = busy_r;
  assign err_timeout  = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed stimulus for uart_tx_arbiter,
// checked against a round-robin reference model and a simple uart_tx model.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int LT    = 40;
  localparam int GC    = 8;
  localparam int DLY   = 10;
  localparam int FRAME = 20;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           uart_ready;
  logic           uart_start_n;
  logic [7:0]     uart_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_timeout;
  logic           clr_err;

  uart_tx_arbiter #(.N_REQ(N), .LAUNCH_TIMEOUT(LT), .GUARD_CLKS(GC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .uart_ready(uart_ready), .uart_start_n(uart_start_n),
    .uart_data(uart_data), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         m_last;
  logic [7:0] m_data;
  int         uart_mode;   // 0: fast frame model, 1: ready stuck high, 2: bench-driven
  int         uart_cnt, frame_cnt;
  logic       prev_sn;
  int         cyc, fall_cyc, rdy_rise_cyc;
  bit         rdy_rise_ok;
  int         falls, ack_count;
  bit         hold_after_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (((v >> i) & 1) != 0) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_last      = N - 1;
    m_data      = 8'h00;
    prev_sn     = 1'b1;
    uart_cnt    = 0;
    frame_cnt   = 0;
    rdy_rise_ok = 1'b0;
  endtask

  // One clock: sample at negedge, check against the model, advance the uart model.
  task automatic step();
    logic [N-1:0]   v_e;
    logic [8*N-1:0] d_e;
    int             exp_i, lowlen;
    logic           fall, rise;
    v_e = req_valid;
    d_e = req_data;
    @(negedge clk);
    cyc++;
    fall    = prev_sn && !uart_start_n;
    rise    = !prev_sn && uart_start_n;
    prev_sn = uart_start_n;
    if (req_ack != '0) begin
      exp_i = -1;
      for (int k = 1; k <= N; k++)
        if (exp_i < 0 && (((v_e >> ((m_last + k) % N)) & 1) != 0)) exp_i = (m_last + k) % N;
      ack_count++;
      if (exp_i < 0) begin
        check("ack_unrequested", req_ack, 32'd0);
      end else begin
        check("ack_onehot", req_ack, 32'(1) << exp_i);
        check("grant_id", grant_id, exp_i);
        check("data_latch", uart_data, 8'(d_e >> (8 * exp_i)));
        m_last = exp_i;
        m_data = 8'(d_e >> (8 * exp_i));
        if (!hold_after_ack) req_valid = req_valid & ~(N'(1) << exp_i);
      end
    end
    if (fall) begin
      falls++;
      check("fall_with_ack", req_ack != '0, 1'b1);
      if (rdy_rise_ok) check("guard_gap", (cyc - rdy_rise_cyc) >= GC + 2, 1'b1);
      rdy_rise_ok = 1'b0;
      fall_cyc = cyc;
      if (uart_mode == 0) uart_cnt = DLY;
    end
    if (rise) begin
      check("data_hold", uart_data, m_data);
      if (uart_mode == 0) begin
        lowlen = cyc - fall_cyc;
        check("launch_len", (lowlen >= DLY + 2) && (lowlen <= DLY + 4), 1'b1);
      end
    end
    if (uart_mode == 0 && !fall) begin
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin uart_ready = 1'b0; frame_cnt = FRAME; end
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) begin uart_ready = 1'b1; rdy_rise_cyc = cyc; rdy_rise_ok = 1'b1; end
      end
    end
  endtask

  task automatic wait_ack(input int budget, output int idx);
    idx = -1;
    for (int n = 0; n < budget && idx < 0; n++) begin
      step();
      if (req_ack != '0) idx = oh2i(req_ack);
    end
    check("ack_seen", idx >= 0, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget && busy; n++) step();
    check("busy_low", busy, 1'b0);
  endtask

  task automatic do_reset(input logic rdy);
    #2;
    rst        = 1'b1;
    req_valid  = '0;
    uart_ready = rdy;
    clr_err    = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Counts cycles with start_n low; optionally pulses clr_err on the last one.
  task automatic low_run(input bit clr_last, output int lowcnt);
    lowcnt = 0;
    while (!uart_start_n && lowcnt < LT + 10) begin
      lowcnt++;
      clr_err = clr_last && (lowcnt == LT);
      step();
      clr_err = 1'b0;
    end
  endtask

  int idx, a0, f0, lowcnt, g, n, target;
  logic [7:0] b;

  initial begin
    req_valid = '0; req_data = '0; uart_ready = 1'b1; clr_err = 1'b0;
    uart_mode = 0; hold_after_ack = 1'b0; cyc = 0; falls = 0; ack_count = 0;
    fall_cyc = 0; rdy_rise_cyc = 0;
    model_reset();

    // Reset values.
    do_reset(1'b1);
    step();
    check("rst_start_n", uart_start_n, 1'b1);
    check("rst_data", uart_data, 8'h00);
    check("rst_ack", req_ack, 4'h0);
    check("rst_gid", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);

    // Single request from requester 2.
    f0 = falls; a0 = ack_count;
    req_data = 32'h005A_0000; req_valid = 4'b0100;
    wait_ack(50, idx);
    check("t1_idx", idx, 2);
    check("t1_data", uart_data, 8'h5A);
    wait_idle(300);
    repeat (5) step();
    check("t1_falls", falls - f0, 1);
    check("t1_acks", ack_count - a0, 1);

    // All four held continuously: order 0,1,2,3,0.
    do_reset(1'b1);
    hold_after_ack = 1'b1;
    req_data = 32'h1312_1110; req_valid = 4'hF;
    for (int j = 0; j < 5; j++) begin
      wait_ack(400, idx);
      check("rr_order", idx, j % N);
    end
    req_valid = '0; hold_after_ack = 1'b0;
    wait_idle(300);

    // Requester 1, then 1 and 3 together: 3 goes before 1.
    req_data = 32'hA3A2_A1A0; req_valid = 4'b0010;
    wait_ack(400, idx);
    check("t4_first", idx, 1);
    req_valid = 4'b1010;
    wait_ack(400, idx);
    check("t4_second", idx, 3);
    wait_ack(400, idx);
    check("t4_third", idx, 1);
    wait_idle(300);

    // Transmitter never drops ready: launch timeout and error flag handling.
    uart_mode = 1; uart_ready = 1'b1;
    check("err_pre", err_timeout, 1'b0);
    hold_after_ack = 1'b1;
    req_data = 32'h0000_00E7; req_valid = 4'b0001;
    wait_ack(50, idx);
    low_run(1'b0, lowcnt);
    check("to_len", lowcnt, LT);
    check("to_err", err_timeout, 1'b1);
    g = 0;
    while (uart_start_n && g < GC + 20) begin
      clr_err = (g == 1);
      g++;
      step();
      clr_err = 1'b0;
      if (g == 2) check("err_clr", err_timeout, 1'b0);
    end
    check("guard_len", g, GC + 2);
    low_run(1'b1, lowcnt);
    check("to_len2", lowcnt, LT);
    check("err_set_wins", err_timeout, 1'b1);
    req_valid = '0; hold_after_ack = 1'b0;
    wait_idle(200);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("err_clr2", err_timeout, 1'b0);

    // Reset in the middle of a launch.
    uart_mode = 0;
    req_data = 32'h0077_0000; req_valid = 4'b0100;
    wait_ack(50, idx);
    check("t6_in_launch", uart_start_n, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t6_start_n", uart_start_n, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_ack", req_ack, 4'h0);
    check("t6_data", uart_data, 8'h00);
    model_reset(); req_valid = '0; uart_ready = 1'b1;
    step();
    rst = 1'b0;
    req_data = 32'h4400_0011; req_valid = 4'b1001;
    wait_ack(50, idx);
    check("t6_regrant", idx, 0);
    req_valid = '0;
    wait_idle(300);

    // uart_ready low at reset release: no grant until it rises.
    uart_mode = 2;
    do_reset(1'b0);
    a0 = ack_count;
    req_data = 32'h0000_00C3; req_valid = 4'b0001;
    repeat (20) step();
    check("t7_no_grant", ack_count - a0, 0);
    uart_ready = 1'b1; uart_mode = 0;
    n = 0; idx = -1;
    while (idx < 0 && n < 20) begin
      n++;
      step();
      if (req_ack != '0) idx = oh2i(req_ack);
    end
    check("t7_idx", idx, 0);
    check("t7_latency", (n >= 3) && (n <= 4), 1'b1);
    wait_idle(300);

    // Randomized requesters with occasional withdrawn requests.
    target = ack_count + 30;
    for (int s = 0; s < 8000 && ack_count < target; s++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (((req_valid >> i) & 1) == 0) begin
          if ($urandom_range(0, 15) == 0) begin
            b = 8'($urandom);
            req_data = (req_data & ~((8*N)'(8'hFF) << (8 * i))) | ((8*N)'(b) << (8 * i));
            req_valid = req_valid | (N'(1) << i);
          end
        end else if ($urandom_range(0, 199) == 0) begin
          req_valid = req_valid & ~(N'(1) << i);
        end
      end
    end
    check("rand_acks", ack_count >= target, 1'b1);
    req_valid = '0;
    wait_idle(400);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `N_REQ` byte-producing requesters. It accepts one byte at a time from the granted requester and drives the transmitter's `start_n`/`data` pins. It tracks the transmitter's `ready_to_send` status to pace frames, and recovers from a launch that the transmitter never acknowledges. It sits between the system-side byte sources (debug console, status reporter, etc.) and the single `uart_tx` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `LAUNCH_TIMEOUT`, 325*16*4: clk cycles allowed for the transmitter to drop ready after `start_n` falls.
- `GUARD_CLKS`, 325*16: clk cycles `uart_start_n` is held high before any new launch. Must be at least one UART bit period.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: requester i has a byte pending; held until acked.
- `req_data` in 8*N_REQ: requester i's byte is at bits [8i+7:8i].
- `req_ack` out N_REQ: one-hot, one-cycle pulse; the byte is consumed.
- `uart_ready` in 1: `ready_to_send` from `uart_tx`. It originates in the baud domain and is synchronized internally.
- `uart_start_n` out 1: to `uart_tx start_n`; falling edge launches a frame.
- `uart_data` out 8: to `uart_tx data`; stable for the whole frame.
- `grant_id` out $clog2(N_REQ): requester whose byte is or was last in flight.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; set when a launch times out.
- `clr_err` in 1: synchronous clear of `err_timeout`.

## Operation
- `uart_ready` passes through a 2-flop synchronizer, producing `rdy_s`. All decisions use `rdy_s`.
- Round-robin pointer `last`:
  - Resets to N_REQ-1.
  - The search starts at `last+1`, wraps modulo N_REQ, and takes the first set `req_valid`.
- States:
  - **IDLE**: `uart_start_n`=1. If `rdy_s`=1 and any `req_valid`:
    - Select winner i.
    - Latch `req_data[i]` into `uart_data`.
    - Set `grant_id`=i and `last`=i.
    - Pulse `req_ack[i]`.
    - Go to LAUNCH.
  - **LAUNCH**: `uart_start_n`=0 and the cycle counter increments.
    - If `rdy_s`=0, go to DRAIN.
    - Otherwise, if the counter reaches LAUNCH_TIMEOUT-1: set `err_timeout`, drop the byte, go to DRAIN.
  - **DRAIN**: `uart_start_n`=1 and `uart_data` is held. When `rdy_s`=1, clear the counter and go to GUARD.
  - **GUARD**: `uart_start_n`=1. Count GUARD_CLKS cycles, then go to IDLE.
- `uart_data` changes only on a grant in IDLE and is otherwise held.
- A byte is never retried. Once `req_ack` has fired, the byte is owned by the arbiter.
- A `req_valid` that drops before being acked is simply not granted.
- `clr_err` clears `err_timeout`. If a timeout sets the flag in the same cycle, the set wins.
- Counter width is $clog2(max(LAUNCH_TIMEOUT, GUARD_CLKS)+1). The counter saturates and never wraps.

## Timing
- Reset values (all asynchronous):
  - State: IDLE.
  - Outputs: `uart_start_n`=1, `uart_data`=0, `req_ack`=0, `grant_id`=0, `busy`=0, `err_timeout`=0.
  - Internal: `last`=N_REQ-1, counter=0, synchronizer flops=1.
- Grant latency: the grant happens on the first clk edge where the IDLE conditions hold. On the following edge, `req_ack` and the new `uart_data` are visible, and `uart_start_n` falls in LAUNCH.
- Frame pacing: `uart_start_n` stays low until the synchronized ready falls, 2-3 clks after `uart_ready` falls. `uart_data` stays constant from the grant until the next grant.
- Back-to-back turnaround: `uart_ready` rising, plus 2-3 clks synchronizer delay, plus GUARD_CLKS, then the next grant is possible.
- Simultaneous requests are resolved in one cycle. Requesters not granted see no ack and keep waiting.
- Reset asserted mid-frame: outputs return to their reset values immediately, and the in-flight byte is lost.
- After reset, the first grant waits until `rdy_s`=1.

## Test plan
- Single request, fast UART model (ready drops 10 clks after `start_n` falls):
  - Stimulus: `req_valid[2]`=1, `req_data[2]`=0x5A.
  - Required: one `req_ack[2]` pulse, `uart_data`=0x5A, `grant_id`=2, exactly one `start_n` falling edge, `busy` returns low after DRAIN+GUARD.
- All four requesters valid with bytes 0x10..0x13, held continuously:
  - Required grant order: 0,1,2,3,0.
  - `start_n` stays high at least GUARD_CLKS between launches.
- Requesters 1 and 3 valid after grant 1:
  - Required: next grant is 3, then 1.
- `uart_ready` held high forever:
  - Required: `start_n` low for exactly LAUNCH_TIMEOUT clks, then `err_timeout`=1 and the byte is acked and dropped.
  - Then `clr_err` clears the flag.
  - A `clr_err` pulse in the same cycle as the timeout leaves the flag at 1.
- `rst` asserted during LAUNCH, then released:
  - Required: `uart_start_n`=1, `busy`=0, `req_ack`=0 immediately.
  - The next grant goes to requester 0 when its `req_valid` is high.
- `uart_ready`=0 at reset release, `req_valid[0]`=1:
  - Required: no grant until `uart_ready` rises plus 2 clks.
